// File: rtl/ser8_tx_if.sv
// ser8_tx_if: valid/ready byte handshake between a byte source and the serializer.
interface ser8_tx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ser8_tx.sv
// ser8_tx: soft 8:1 SDR serializer with word clock, frame marker and one-entry holding buffer.
module ser8_tx #(
   parameter bit         MSB_FIRST = 1'b0,
   parameter logic [7:0] IDLE_WORD = 8'h00
) (
   input  logic     clk_i,
   input  logic     rst_i,
   ser8_tx_if.slave src_if,
   input  logic     bitslip_i,
   output logic     ser_o,
   output logic     frame_o,
   output logic     pclk_o,
   output logic     busy_o,
   output logic     underrun_o
);
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d, buf_q, buf_d, sh_next;
   logic       full_q, full_d, rdy_q, rdy_d, busy_q, busy_d, und_q, und_d;
   logic       bnd, acc;
   always_comb begin
      bnd     = (cnt_q == 3'd7) && !bitslip_i;
      acc     = src_if.valid && !full_q;
      sh_next = MSB_FIRST ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
      cnt_d   = bitslip_i ? cnt_q : cnt_q + 3'd1;
      // boundary load priority: buffered word, then bypass, then idle
      sh_d    = bnd ? (full_q ? buf_q : acc ? src_if.data : IDLE_WORD) : bitslip_i ? sh_q : sh_next;
      busy_d  = bnd ? (full_q || acc) : busy_q;
      und_d   = bnd && !full_q && !acc && busy_q;
      full_d  = bnd ? 1'b0 : (full_q || acc);
      buf_d   = (acc && !bnd) ? src_if.data : buf_q;
      rdy_d   = !full_d;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= 3'd0;
         sh_q   <= IDLE_WORD;
         buf_q  <= 8'h00;
         full_q <= 1'b0;
         rdy_q  <= 1'b1;
         busy_q <= 1'b0;
         und_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sh_q   <= sh_d;
         buf_q  <= buf_d;
         full_q <= full_d;
         rdy_q  <= rdy_d;
         busy_q <= busy_d;
         und_q  <= und_d;
      end
   end
   assign src_if.ready = rdy_q;
   assign ser_o        = MSB_FIRST ? sh_q[7] : sh_q[0];
   assign frame_o      = (cnt_q == 3'd0);
   assign pclk_o       = !cnt_q[2];
   assign busy_o       = busy_q;
   assign underrun_o   = und_q;
endmodule
